// File: rtl/clock_enable_gen.sv
// Lock qualifier and reset release behind the PLL, plus NUM_CH phase-accumulator
// clock-enable generators with run-time writable increments and a lock-loss counter.
module clock_enable_gen #(
  parameter int                        NUM_CH     = 2,
  parameter int                        ACC_W      = 24,
  parameter logic [NUM_CH*ACC_W-1:0]   INC_INIT   = {24'd333876, 24'd328949},
  parameter int                        LOCK_HOLD  = 1024,
  parameter int                        LOSS_CNT_W = 4
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic                                             locked_in,
  input  logic                                             inc_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]   inc_sel,
  input  logic [ACC_W-1:0]                                 inc_data,
  output logic                                             rst_out,
  output logic                                             ready,
  output logic [NUM_CH-1:0]                                ce,
  output logic [NUM_CH-1:0]                                phase,
  output logic [LOSS_CNT_W-1:0]                            loss_count
);

  localparam int CNT_W = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(LOCK_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_FIRST = CNT_W'(1);

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]            sync_q;
  logic                  lk_s;
  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rst_q, rst_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic [NUM_CH-1:0]     ce_q, ce_d;
  logic [ACC_W-1:0]      acc_q [NUM_CH];
  logic [ACC_W-1:0]      acc_d [NUM_CH];
  logic [ACC_W-1:0]      inc_q [NUM_CH];
  logic [ACC_W-1:0]      inc_d [NUM_CH];
  logic [ACC_W:0]        sum   [NUM_CH];
  logic                  sel_ok;

  assign lk_s       = sync_q[1];
  assign sel_ok     = (int'(inc_sel) < NUM_CH);
  assign rst_out    = rst_q;
  assign ready      = ~rst_q;
  assign ce         = ce_q;
  assign loss_count = loss_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign sum[g]   = {1'b0, acc_q[g]} + {1'b0, inc_q[g]};
    assign phase[g] = acc_q[g][ACC_W-1];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    loss_d  = loss_q;
    ce_d    = ce_q;
    acc_d   = acc_q;
    inc_d   = inc_q;

    case (state_q)
      ST_WAIT: begin
        cnt_d = '0;
        ce_d  = '0;
        for (int i = 0; i < NUM_CH; i++) acc_d[i] = '0;
        // The cycle that leaves WAIT is already the first qualified lock cycle.
        if (lk_s) begin
          if (LOCK_HOLD == 1) begin
            state_d = ST_RUN;
            rst_d   = 1'b0;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_FIRST;
          end
        end
      end
      ST_HOLD: begin
        if (!lk_s) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          rst_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lk_s) begin
          state_d = ST_WAIT;
          rst_d   = 1'b1;
          loss_d  = (loss_q == '1) ? loss_q : loss_q + 1'b1;
          ce_d    = '0;
          for (int i = 0; i < NUM_CH; i++) acc_d[i] = '0;
        end else begin
          for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i] = sum[i][ACC_W-1:0];
            ce_d[i]  = sum[i][ACC_W];
          end
        end
      end
      default: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
        rst_d   = 1'b1;
        ce_d    = '0;
        for (int i = 0; i < NUM_CH; i++) acc_d[i] = '0;
      end
    endcase

    // Increment writes never touch the accumulator, keeping rate changes phase-continuous.
    if (inc_we && sel_ok) inc_d[inc_sel] = inc_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= ST_WAIT;
      cnt_q   <= '0;
      rst_q   <= 1'b1;
      loss_q  <= '0;
      ce_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
        inc_q[i] <= INC_INIT[i*ACC_W +: ACC_W];
      end
    end else begin
      sync_q  <= {sync_q[0], locked_in};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      loss_q  <= loss_d;
      ce_q    <= ce_d;
      acc_q   <= acc_d;
      inc_q   <= inc_d;
    end
  end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Bench for clock_enable_gen: directed release/glitch/rate/write/loss/reset steps plus a
// randomized segment, every cycle compared against a rate-and-streak reference model.
module tb_clock_enable_gen;
  localparam int NUM_CH     = 3;
  localparam int ACC_W      = 4;
  localparam int LOCK_HOLD  = 8;
  localparam int LOSS_CNT_W = 4;
  localparam int MOD        = 2 ** ACC_W;
  localparam int LOSS_MAX   = 2 ** LOSS_CNT_W - 1;
  localparam logic [NUM_CH*ACC_W-1:0] INC_INIT = {4'd15, 4'd0, 4'd4};

  logic                  clock = 1'b0;
  logic                  reset, locked_in, inc_we;
  logic [1:0]            inc_sel;
  logic [ACC_W-1:0]      inc_data;
  logic                  rst_out, ready;
  logic [NUM_CH-1:0]     ce, phase;
  logic [LOSS_CNT_W-1:0] loss_count;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  clock_enable_gen #(
    .NUM_CH(NUM_CH), .ACC_W(ACC_W), .INC_INIT(INC_INIT),
    .LOCK_HOLD(LOCK_HOLD), .LOSS_CNT_W(LOSS_CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .locked_in(locked_in),
    .inc_we(inc_we), .inc_sel(inc_sel), .inc_data(inc_data),
    .rst_out(rst_out), .ready(ready), .ce(ce), .phase(phase),
    .loss_count(loss_count)
  );

  // Reference model: lock streak counting, integer modulo accumulators.
  int m_acc [NUM_CH];
  int m_inc [NUM_CH];
  bit m_ce  [NUM_CH];
  bit m_run;
  int m_streak;
  int m_loss;
  bit m_hist [$];

  function automatic void model_reset();
    logic [NUM_CH*ACC_W-1:0] init_v;
    init_v = INC_INIT;
    for (int i = 0; i < NUM_CH; i++) begin
      m_acc[i] = 0;
      m_ce[i]  = 0;
      m_inc[i] = int'(init_v[i*ACC_W +: ACC_W]);
    end
    m_run    = 0;
    m_streak = 0;
    m_loss   = 0;
    m_hist   = '{1'b0, 1'b0};
  endfunction

  function automatic void model_edge();
    bit lk;
    int total;
    if (reset) begin
      model_reset();
      return;
    end
    lk = m_hist.pop_front();
    m_hist.push_back(locked_in);
    if (m_run) begin
      if (!lk) begin
        m_run    = 0;
        m_streak = 0;
        m_loss   = (m_loss < LOSS_MAX) ? m_loss + 1 : LOSS_MAX;
        for (int i = 0; i < NUM_CH; i++) begin
          m_acc[i] = 0;
          m_ce[i]  = 0;
        end
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          total    = m_acc[i] + m_inc[i];
          m_ce[i]  = (total >= MOD);
          m_acc[i] = total % MOD;
        end
      end
    end else begin
      m_streak = lk ? m_streak + 1 : 0;
      if (m_streak == LOCK_HOLD) begin
        m_run    = 1;
        m_streak = 0;
      end
    end
    if (inc_we && int'(inc_sel) < NUM_CH) m_inc[inc_sel] = int'(inc_data);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [NUM_CH-1:0] e_ce, e_ph;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    for (int i = 0; i < NUM_CH; i++) begin
      e_ce[i] = m_ce[i];
      e_ph[i] = (m_acc[i] >= MOD / 2);
    end
    chk("model_rst_out", 32'(rst_out), 32'(!m_run));
    chk("model_ready", 32'(ready), 32'(m_run));
    chk("model_ce", 32'(ce), 32'(e_ce));
    chk("model_phase", 32'(phase), 32'(e_ph));
    chk("model_loss", 32'(loss_count), 32'(m_loss));
    inc_we = 1'b0;
  endtask

  task automatic wait_rst(input logic target, input int limit, output int n);
    n = 0;
    while (rst_out !== target && n < limit) begin
      tick();
      n++;
    end
    if (rst_out !== target) n = -1;
  endtask

  task automatic count_ce(input int cycles, output int c0, output int c1, output int c2);
    c0 = 0; c1 = 0; c2 = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      c0 += int'(ce[0]);
      c1 += int'(ce[1]);
      c2 += int'(ce[2]);
    end
  endtask

  initial begin
    int n, c0, c1, c2;
    model_reset();
    reset = 1'b1; locked_in = 1'b0; inc_we = 1'b0; inc_sel = '0; inc_data = '0;

    // Reset state.
    tick();
    chk("reset_rst_out", 32'(rst_out), 32'd1);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_ce", 32'(ce), 32'd0);
    chk("reset_phase", 32'(phase), 32'd0);
    chk("reset_loss", 32'(loss_count), 32'd0);

    // Release: lock high from edge 1, reset held through edge 9, released at edge 10.
    reset = 1'b0; locked_in = 1'b1;
    for (int e = 1; e <= LOCK_HOLD + 1; e++) begin
      tick();
      chk("release_held", 32'(rst_out), 32'd1);
    end
    tick();
    chk("release_rst_out", 32'(rst_out), 32'd0);
    chk("release_ready", 32'(ready), 32'd1);
    chk("release_loss", 32'(loss_count), 32'd0);

    // Rates: inc0=4, inc1=0, inc2=15 over a 16-cycle window.
    count_ce(16, c0, c1, c2);
    chk("rate_inc4", 32'(c0), 32'd4);
    chk("rate_inc0", 32'(c1), 32'd0);
    chk("rate_inc15", 32'(c2), 32'd15);

    // Live write when acc0 is 8: acc0 then runs 12,13,14,15,0.
    n = 0;
    while (m_acc[0] != 8 && n < 8) begin
      tick();
      n++;
    end
    chk("live_reach_acc8", 32'(m_acc[0]), 32'd8);
    inc_we = 1'b1; inc_sel = 2'd0; inc_data = 4'd1;
    tick();
    chk("live_phase_12", 32'(phase[0]), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("live_no_ce", 32'(ce[0]), 32'd0);
      chk("live_phase_hi", 32'(phase[0]), 32'd1);
    end
    tick();
    chk("live_wrap_ce", 32'(ce[0]), 32'd1);
    chk("live_wrap_phase", 32'(phase[0]), 32'd0);
    inc_we = 1'b1; inc_sel = 2'd3; inc_data = 4'd7;
    tick();
    count_ce(16, c0, c1, c2);
    chk("sel_oob_ignored", 32'(c0), 32'd1);

    // Lock losses, the last two beyond saturation; a write lands on each loss edge.
    for (int k = 0; k < 17; k++) begin
      repeat ($urandom_range(1, 12)) begin
        inc_we   = ($urandom_range(0, 3) == 0);
        inc_sel  = 2'($urandom_range(0, 3));
        inc_data = 4'($urandom);
        tick();
      end
      locked_in = 1'b0;
      tick();
      chk("loss_edge1", 32'(rst_out), 32'd0);
      tick();
      chk("loss_edge2", 32'(rst_out), 32'd0);
      inc_we = 1'b1; inc_sel = 2'd1; inc_data = 4'($urandom);
      tick();
      chk("loss_edge3", 32'(rst_out), 32'd1);
      chk("loss_ce", 32'(ce), 32'd0);
      chk("loss_phase", 32'(phase), 32'd0);
      locked_in = 1'b1;
      wait_rst(1'b0, 40, n);
      chk("relock_edges", 32'(n), 32'(LOCK_HOLD + 2));
    end
    chk("loss_saturated", 32'(loss_count), 32'(LOSS_MAX));

    // Mid-run reset with inc0 rewritten.
    inc_we = 1'b1; inc_sel = 2'd0; inc_data = 4'd9;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_rst_out", 32'(rst_out), 32'd1);
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_ce", 32'(ce), 32'd0);
    chk("midrst_phase", 32'(phase), 32'd0);
    chk("midrst_loss", 32'(loss_count), 32'd0);
    reset = 1'b0;
    wait_rst(1'b0, 40, n);
    chk("midrst_release", 32'(n), 32'(LOCK_HOLD + 2));
    count_ce(16, c0, c1, c2);
    chk("midrst_inc0_init", 32'(c0), 32'd4);

    // One-cycle glitch in HOLD: lock sampled low at edge 6 pushes release to edge 16.
    reset = 1'b1; locked_in = 1'b0;
    tick();
    reset = 1'b0; locked_in = 1'b1;
    repeat (5) tick();
    locked_in = 1'b0;
    tick();
    locked_in = 1'b1;
    wait_rst(1'b0, 40, n);
    chk("glitch_release", 32'(n + 6), 32'd16);
    chk("glitch_loss", 32'(loss_count), 32'd0);

    // Randomized segment: lock drops, writes (including out-of-range), rare resets.
    for (int k = 0; k < 600; k++) begin
      if (locked_in) locked_in = ($urandom_range(0, 39) != 0);
      else           locked_in = ($urandom_range(0, 2) == 0);
      inc_we   = ($urandom_range(0, 5) == 0);
      inc_sel  = 2'($urandom_range(0, 3));
      inc_data = 4'($urandom);
      reset    = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
